// File: rtl/vmode_pkg.sv
// Shared timing defaults and scan-region classification for the video scan-out path.
package vmode_pkg;

    // Default 320x200 timing (pixel clocks per horizontal region, lines per vertical region)
    localparam int   DEF_H_ACTIVE      = 32'sd320;
    localparam int   DEF_H_FRONT       = 32'sd8;
    localparam int   DEF_H_SYNC        = 32'sd32;
    localparam int   DEF_H_BACK        = 32'sd40;
    localparam int   DEF_V_ACTIVE      = 32'sd200;
    localparam int   DEF_V_FRONT       = 32'sd3;
    localparam int   DEF_V_SYNC        = 32'sd6;
    localparam int   DEF_V_BACK        = 32'sd16;
    localparam logic DEF_SYNC_POL      = 1'b0;
    localparam int   DEF_RDATA_LATENCY = 32'sd1;

    // Position of a counter within one axis of the raster
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_e;

    // Classify a counter value; regions follow ACTIVE, FRONT, SYNC, BACK in order
    function automatic region_e axis_region(
        input logic [9:0] cnt,
        input logic [9:0] active_len,
        input logic [9:0] front_len,
        input logic [9:0] sync_len
    );
        region_e region;
        if (cnt < active_len) begin
            region = ACTIVE;
        end else if (cnt < (active_len + front_len)) begin
            region = FRONT;
        end else if (cnt < (active_len + front_len + sync_len)) begin
            region = SYNC;
        end else begin
            region = BACK;
        end
        return region;
    endfunction

endpackage

// File: rtl/vmode_delay.sv
// Fixed-depth shift register with synchronous clear; DEPTH of zero is a wire.
module vmode_delay
    import vmode_pkg::*;
#(
    parameter int WIDTH = 32'sd1,
    parameter int DEPTH = 32'sd1
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 32'sd0) begin : g_bypass
            logic unused_bypass_s;
            assign unused_bypass_s = i_clock ^ i_clear;
            assign o_data          = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Advance the pipeline one stage per clock; clear empties every stage at once
            always_ff @(posedge i_clock) begin
                if (i_clear) begin
                    for (int i = 32'sd0; i < DEPTH; i++) begin
                        stage_r[i] <= '0;
                    end
                end else begin
                    stage_r[0] <= i_data;
                    for (int i = 32'sd1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign o_data = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vmode_scanout.sv
// Raster scan-out: walks the frame, requests pixels, and re-aligns sync/enable
// with the returned pixel data so every output describes the same pixel.
module vmode_scanout
    import vmode_pkg::*;
#(
    parameter int   H_ACTIVE      = DEF_H_ACTIVE,
    parameter int   H_FRONT       = DEF_H_FRONT,
    parameter int   H_SYNC        = DEF_H_SYNC,
    parameter int   H_BACK        = DEF_H_BACK,
    parameter int   V_ACTIVE      = DEF_V_ACTIVE,
    parameter int   V_FRONT       = DEF_V_FRONT,
    parameter int   V_SYNC        = DEF_V_SYNC,
    parameter int   V_BACK        = DEF_V_BACK,
    parameter logic SYNC_POL      = DEF_SYNC_POL,
    parameter int   RDATA_LATENCY = DEF_RDATA_LATENCY
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_enable,
    output logic        o_video_request,
    output logic [8:0]  o_video_pos_x,
    output logic [8:0]  o_video_pos_y,
    input  logic [31:0] i_video_rdata,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_data_enable,
    output logic [23:0] o_rgb,
    output logic        o_frame_start
);

    localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
    localparam logic [9:0] H_FRT_C   = 10'(H_FRONT);
    localparam logic [9:0] H_SYN_C   = 10'(H_SYNC);
    localparam logic [9:0] H_TOTAL_C = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
    localparam logic [9:0] V_FRT_C   = 10'(V_FRONT);
    localparam logic [9:0] V_SYN_C   = 10'(V_SYNC);
    localparam logic [9:0] V_TOTAL_C = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);

    logic [9:0] h_count_r, v_count_r;
    logic [9:0] h_next_s, v_next_s;
    region_e    h_region_s, v_region_s;
    logic       active_s;

    // Stage 0: request side, all describing the pixel currently being requested
    logic       request_r;
    logic [8:0] pos_x_r, pos_y_r;
    logic       hsync_act_r, vsync_act_r, frame_start_r;

    logic       clear_s;
    logic [3:0] timing_s, aligned_s;

    logic        hsync_r, vsync_r, data_enable_r, frame_start_out_r;
    logic [23:0] rgb_r;

    logic unused_rdata_s;
    assign unused_rdata_s = ^i_video_rdata[31:24];

    assign h_region_s = axis_region(h_count_r, H_ACT_C, H_FRT_C, H_SYN_C);
    assign v_region_s = axis_region(v_count_r, V_ACT_C, V_FRT_C, V_SYN_C);
    assign active_s   = (h_region_s == ACTIVE) && (v_region_s == ACTIVE);

    // Next scan position: step along the line, advance the row only on line wrap
    always_comb begin
        h_next_s = h_count_r;
        v_next_s = v_count_r;
        if (h_count_r == (H_TOTAL_C - 10'd1)) begin
            h_next_s = 10'd0;
            if (v_count_r == (V_TOTAL_C - 10'd1)) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_count_r + 10'd1;
            end
        end else begin
            h_next_s = h_count_r + 10'd1;
        end
    end

    // Scan counters and request-side timing; disable parks the raster at (0,0)
    always_ff @(posedge i_clock) begin
        if (!i_reset_n || !i_enable) begin
            h_count_r     <= 10'd0;
            v_count_r     <= 10'd0;
            request_r     <= 1'b0;
            pos_x_r       <= 9'd0;
            pos_y_r       <= 9'd0;
            hsync_act_r   <= 1'b0;
            vsync_act_r   <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            h_count_r     <= h_next_s;
            v_count_r     <= v_next_s;
            request_r     <= active_s;
            pos_x_r       <= active_s ? h_count_r[8:0] : 9'd0;
            pos_y_r       <= active_s ? v_count_r[8:0] : 9'd0;
            hsync_act_r   <= (h_region_s == SYNC);
            vsync_act_r   <= (v_region_s == SYNC);
            frame_start_r <= active_s && (h_count_r == 10'd0) && (v_count_r == 10'd0);
        end
    end

    // Hold timing flags for the read latency so they meet the returned pixel data;
    // only reset clears it, so a disable lets in-flight pixels drain out
    assign clear_s  = !i_reset_n;
    assign timing_s = {hsync_act_r, vsync_act_r, request_r, frame_start_r};

    vmode_delay #(
        .WIDTH (32'sd4),
        .DEPTH (RDATA_LATENCY)
    ) u_timing_delay (
        .i_clock (i_clock),
        .i_clear (clear_s),
        .i_data  (timing_s),
        .o_data  (aligned_s)
    );

    // Output register: capture pixel colour and apply sync polarity in one stage
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            hsync_r           <= ~SYNC_POL;
            vsync_r           <= ~SYNC_POL;
            data_enable_r     <= 1'b0;
            rgb_r             <= 24'd0;
            frame_start_out_r <= 1'b0;
        end else begin
            hsync_r           <= aligned_s[3] ? SYNC_POL : ~SYNC_POL;
            vsync_r           <= aligned_s[2] ? SYNC_POL : ~SYNC_POL;
            data_enable_r     <= aligned_s[1];
            rgb_r             <= aligned_s[1] ? i_video_rdata[23:0] : 24'd0;
            frame_start_out_r <= aligned_s[0];
        end
    end

    assign o_video_request = request_r;
    assign o_video_pos_x   = pos_x_r;
    assign o_video_pos_y   = pos_y_r;
    assign o_hsync         = hsync_r;
    assign o_vsync         = vsync_r;
    assign o_data_enable   = data_enable_r;
    assign o_rgb           = rgb_r;
    assign o_frame_start   = frame_start_out_r;

endmodule

// File: tb/tb_vmode_scanout.sv
// Self-checking bench for vmode_scanout with a small 8x4 raster (14x7 total).
module tb_vmode_scanout;

    localparam int HT  = 14;   // 8 active + 2 front + 2 sync + 2 back
    localparam int VT  = 7;    // 4 active + 1 front + 1 sync + 1 back
    localparam int FT  = HT * VT;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] rdata;
    logic        o_video_request;
    logic [8:0]  o_video_pos_x, o_video_pos_y;
    logic        o_hsync, o_vsync, o_data_enable, o_frame_start;
    logic [23:0] o_rgb;

    vmode_scanout #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b0), .RDATA_LATENCY(1)
    ) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_enable       (en),
        .o_video_request(o_video_request),
        .o_video_pos_x  (o_video_pos_x),
        .o_video_pos_y  (o_video_pos_y),
        .i_video_rdata  (rdata),
        .o_hsync        (o_hsync),
        .o_vsync        (o_vsync),
        .o_data_enable  (o_data_enable),
        .o_rgb          (o_rgb),
        .o_frame_start  (o_frame_start)
    );

    typedef struct packed {
        logic       req;
        logic [8:0] x;
        logic [8:0] y;
        logic       hs;
        logic       vs;
        logic       fs;
    } rec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n = -1;          // pixels scanned since the raster was (re)started, -1 when idle
    rec_t hist0, hist1, hist2;  // expected state now, one cycle ago, two cycles ago

    int first_req, first_de, first_hs, cnt_de, cnt_vs, last_fs, fs_interval;
    logic [8:0] saved_x, saved_y;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What the raster shows at scan index k, from plain arithmetic on the frame geometry
    function automatic rec_t pixel_rec(input int k);
        rec_t r;
        int h, v;
        logic act;
        h   = k % HT;
        v   = (k / HT) % VT;
        act = (h < 8) && (v < 4);
        r.req = act;
        r.x   = act ? 9'(h) : 9'd0;
        r.y   = act ? 9'(v) : 9'd0;
        r.hs  = (h >= 10) && (h < 12);
        r.vs  = (v == 5);
        r.fs  = ((k % FT) == 0);
        return r;
    endfunction

    // Model: advance the scan index on each edge; outputs lag requests by two cycles
    initial begin
        hist0 = '0; hist1 = '0; hist2 = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                n = -1;
                hist0 = '0; hist1 = '0; hist2 = '0;
            end else begin
                hist2 = hist1;
                hist1 = hist0;
                if (!en) begin
                    n = -1;
                    hist0 = '0;
                end else begin
                    n = n + 1;
                    hist0 = pixel_rec(n);
                end
            end
        end
    end

    // Compare every cycle, gather frame statistics, and act as the pixel memory
    initial begin
        rdata = 32'd0; saved_x = 9'd0; saved_y = 9'd0;
        first_req = -1; first_de = -1; first_hs = -1;
        cnt_de = 0; cnt_vs = 0; last_fs = -1; fs_interval = -1;
        forever begin
            @(negedge clk);
            chk("request", {31'd0, o_video_request}, {31'd0, hist0.req});
            chk("pos_x", {23'd0, o_video_pos_x}, {23'd0, hist0.x});
            chk("pos_y", {23'd0, o_video_pos_y}, {23'd0, hist0.y});
            chk("hsync", {31'd0, o_hsync}, {31'd0, !hist2.hs});
            chk("vsync", {31'd0, o_vsync}, {31'd0, !hist2.vs});
            chk("data_enable", {31'd0, o_data_enable}, {31'd0, hist2.req});
            chk("rgb", {8'd0, o_rgb}, {8'd0, (hist2.req ? {6'd0, hist2.y, hist2.x} : 24'd0)});
            chk("frame_start", {31'd0, o_frame_start}, {31'd0, hist2.fs});
            if (o_video_request && first_req < 0) first_req = cyc;
            if (o_data_enable && first_de < 0) first_de = cyc;
            if (!o_hsync && first_hs < 0) first_hs = cyc;
            if (o_data_enable) cnt_de++;
            if (!o_vsync) cnt_vs++;
            if (o_frame_start) begin
                if (last_fs >= 0) fs_interval = cyc - last_fs;
                last_fs = cyc;
            end
            rdata   = {14'd0, saved_y, saved_x};
            saved_x = o_video_pos_x;
            saved_y = o_video_pos_y;
        end
    end

    task automatic arm();
        first_req = -1; first_de = -1; first_hs = -1;
        cnt_de = 0; cnt_vs = 0; last_fs = -1; fs_interval = -1;
    endtask

    // First line after a (re)start: eight requests at x = 0..7 on row 0, then a gap
    task automatic start_seq();
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) begin
            chk("start_request", {31'd0, o_video_request}, 32'd1);
            chk("start_pos_x", {23'd0, o_video_pos_x}, i);
            chk("start_pos_y", {23'd0, o_video_pos_y}, 32'd0);
            @(posedge clk); #2;
        end
        chk("start_front_porch", {31'd0, o_video_request}, 32'd0);
    endtask

    initial begin
        logic found;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_request", {31'd0, o_video_request}, 32'd0);
        chk("reset_hsync", {31'd0, o_hsync}, 32'd1);
        chk("reset_vsync", {31'd0, o_vsync}, 32'd1);
        chk("reset_rgb", {8'd0, o_rgb}, 32'd0);

        // Release and run two full frames
        arm();
        rst_n = 1'b1;
        start_seq();
        repeat (182) @(posedge clk);
        #2;
        chk("req_to_rgb_latency", first_de - first_req, 32'd2);
        chk("hsync_offset", first_hs - first_de, 32'd10);
        chk("frame_start_interval", fs_interval, FT);
        chk("de_cycles_2frames", cnt_de, 32'd64);
        chk("vsync_cycles_2frames", cnt_vs, 32'd28);

        // Drop enable while requesting pixel (3,2)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #2;
            if (o_video_request && o_video_pos_x == 9'd3 && o_video_pos_y == 9'd2) found = 1'b1;
        end
        chk("find_pixel_3_2", {31'd0, found}, 32'd1);
        en = 1'b0;
        @(posedge clk); #2;
        chk("disable_request", {31'd0, o_video_request}, 32'd0);
        chk("disable_pos_x", {23'd0, o_video_pos_x}, 32'd0);
        @(posedge clk); #2;
        chk("drain_last_rgb", {8'd0, o_rgb}, 32'h403);
        @(posedge clk); #2;
        chk("drained_de", {31'd0, o_data_enable}, 32'd0);
        chk("drained_rgb", {8'd0, o_rgb}, 32'd0);
        repeat (3) @(posedge clk);
        #2;

        // Re-enable: raster restarts at (0,0) with a frame start
        arm();
        en = 1'b1;
        @(posedge clk); #2;
        chk("restart_request", {31'd0, o_video_request}, 32'd1);
        chk("restart_pos", {14'd0, o_video_pos_y, o_video_pos_x}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("restart_frame_start", {31'd0, o_frame_start}, 32'd1);
        chk("restart_de", {31'd0, o_data_enable}, 32'd1);

        // Reset in the middle of vertical sync
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #2;
            if (!o_vsync) found = 1'b1;
        end
        chk("find_vsync", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("midreset_vsync", {31'd0, o_vsync}, 32'd1);
        chk("midreset_hsync", {31'd0, o_hsync}, 32'd1);
        chk("midreset_outputs", {o_video_request, o_data_enable, o_frame_start, o_rgb},
            32'd0);
        repeat (2) @(posedge clk);
        #2;
        arm();
        rst_n = 1'b1;
        start_seq();
        repeat (20) @(posedge clk);
        #2;
        chk("rerun_latency", first_de - first_req, 32'd2);
        chk("rerun_hsync_offset", first_hs - first_de, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmode_scanout.md
VMODE_SCANOUT -- requirements
Module: vmode_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 320, visible pixels per line.
REQ-002 Parameter H_FRONT, default 8, H_SYNC default 32, H_BACK default 40; horizontal porch/sync widths in pixel clocks.
REQ-003 Parameter V_ACTIVE, default 200, visible lines per frame.
REQ-004 Parameter V_FRONT, default 3, V_SYNC default 6, V_BACK default 16; vertical porch/sync widths in lines.
REQ-005 Parameter SYNC_POL, default 0, asserted level of o_hsync/o_vsync.
REQ-006 Parameter RDATA_LATENCY, default 1, cycles from o_video_request/pos to valid i_video_rdata.
REQ-007 i_clock  in  1  single clock, one pixel per cycle.
REQ-008 i_reset_n  in  1  synchronous, active-low reset.
REQ-009 i_enable  in  1  scan-out run enable.
REQ-010 o_video_request  out  1  pixel fetch request to video mode block.
REQ-011 o_video_pos_x  out  9  pixel column of current request.
REQ-012 o_video_pos_y  out  9  pixel row of current request.
REQ-013 i_video_rdata  in  32  pixel colour, [23:0] used as RGB.
REQ-014 o_hsync, o_vsync  out  1 each  sync outputs, polarity per SYNC_POL.
REQ-015 o_data_enable  out  1  o_rgb valid (active region).
REQ-016 o_rgb  out  24  pixel colour, zero outside active region.
REQ-017 o_frame_start  out  1  one-cycle pulse aligned with first active pixel of frame on o_rgb.

Function
REQ-018 h_count SHALL run 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; v_count SHALL increment on h_count wrap, run 0..V_TOTAL-1, wrap to 0.
REQ-019 Regions per axis: ACTIVE [0,ACTIVE), FRONT, SYNC, BACK in that order; sync asserted only in SYNC region.
REQ-020 o_video_request SHALL be high exactly when h_count < H_ACTIVE and v_count < V_ACTIVE, registered, with pos_x = h_count, pos_y = v_count in the same cycle.
REQ-021 Outside active region pos_x/pos_y SHALL be 0.
REQ-022 i_video_rdata SHALL be sampled RDATA_LATENCY cycles after its request; o_rgb registered, total latency request-to-o_rgb = RDATA_LATENCY+1 cycles.
REQ-023 o_hsync, o_vsync, o_data_enable, o_frame_start SHALL be delayed by the same RDATA_LATENCY+1 cycles so all outputs are pixel-aligned.
REQ-024 o_vsync SHALL change only on line boundaries (h_count = 0 transition).
REQ-025 i_enable low: counters SHALL load 0 next cycle, request low, pos 0; delayed pipeline keeps draining, then o_data_enable/o_rgb/o_frame_start 0, syncs deasserted.
REQ-026 i_enable rising: scan SHALL start at h_count=0, v_count=0, first request the cycle after i_enable sampled high.
REQ-027 i_enable dropping mid-line SHALL not produce a partial o_frame_start or sync glitch beyond the drained pipeline contents.
REQ-028 All parameter sums SHALL fit in 10-bit counters; pos outputs truncate to 9 bits (H_ACTIVE, V_ACTIVE <= 512).

Reset
REQ-029 i_reset_n low at a clock edge: counters 0, all delay stages cleared, o_video_request 0, pos 0, o_rgb 0, o_data_enable 0, o_frame_start 0, syncs deasserted (~SYNC_POL).
REQ-030 Reset mid-frame SHALL abort immediately; after release scan restarts per REQ-026.

Structure
REQ-031 Shared package vmode_pkg SHALL hold default timing constants and the region enum (ACTIVE, FRONT, SYNC, BACK).
REQ-032 One sub-module vmode_delay (parameterised width/depth shift register with sync clear) SHALL implement REQ-023 alignment.

Verification (H 8/2/2/2, V 4/1/1/1, RDATA_LATENCY 1, SYNC_POL 0)
REQ-033 Reset release with i_enable=1 -> request high cycles 1..8, pos_x 0..7, pos_y 0; hsync low for 2 cycles starting 10 pixels after first request.
REQ-034 Model returns rdata = {pos_y,pos_x} -> o_rgb matches 2 cycles later, o_data_enable high 32 cycles per frame, 0 outside.
REQ-035 Run 2 frames -> o_frame_start every 98 cycles (14x7), vsync low for exactly 14 cycles per frame starting at line 5.
REQ-036 i_enable low at pos_x 3 line 2 -> request low next cycle, outputs blank after 2 cycles; re-enable -> restart at (0,0) with o_frame_start.
REQ-037 i_reset_n low during vsync -> all outputs at reset values next cycle; release -> sequence identical to REQ-033.
